// File: rtl/apb_reg_bridge.sv
// apb_reg_bridge: APB completer forwarding accesses to an indexed register file over a req/ack handshake with timeout.
module apb_reg_bridge #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 5,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 12'h000,
  parameter int REG_STRIDE = 4,
  parameter logic [NUM_REGS-1:0] RO_MASK = 5'b10010,
  parameter int TIMEOUT = 16,
  localparam int STRB_W = DATA_W / 8,
  localparam int IDX_W = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [STRB_W-1:0] pstrb,
  input  logic [DATA_W-1:0] pwdata,
  output logic              pready,
  output logic              pslverr,
  output logic [DATA_W-1:0] prdata,
  output logic              reg_req_o,
  output logic              reg_we_o,
  output logic [IDX_W-1:0]  reg_idx_o,
  output logic [STRB_W-1:0] reg_strb_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  input  logic              reg_ack_i,
  input  logic              reg_err_i,
  input  logic [DATA_W-1:0] reg_rdata_i,
  output logic              timeout_o
);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam int SH = $clog2(REG_STRIDE);
  localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(NUM_REGS * REG_STRIDE);
  localparam logic [ADDR_W-1:0] AMSK = ADDR_W'(REG_STRIDE - 1);
  typedef enum logic [1:0] {IDLE, REQ, ERR, RESP} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic pready_q, pready_d, pslverr_q, pslverr_d, tmo_q, tmo_d;
  logic req_q, req_d, we_q, we_d;
  logic [DATA_W-1:0] prdata_q, prdata_d, wdata_q, wdata_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [STRB_W-1:0] strb_q, strb_d;
  logic [ADDR_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic mapped, dec_err, setup, start, tmo, fin_ack, done;
  assign off = paddr - BASE_ADDR;
  assign idx = IDX_W'(off >> SH);
  assign mapped = paddr >= BASE_ADDR && {1'b0, off} < SPAN && (off & AMSK) == '0;
  assign dec_err = !mapped || (pwrite && RO_MASK[idx]);
  assign setup = psel && !penable;
  assign tmo = cnt_q == CNT_W'(TIMEOUT - 1);
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pready_q <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q <= '0;
      tmo_q <= 1'b0;
      req_q <= 1'b0;
      we_q <= 1'b0;
      idx_q <= '0;
      strb_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pready_q <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q <= prdata_d;
      tmo_q <= tmo_d;
      req_q <= req_d;
      we_q <= we_d;
      idx_q <= idx_d;
      strb_q <= strb_d;
      wdata_q <= wdata_d;
    end
  end
  // A master that drops psel mid-request aborts the access without a response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = setup ? (dec_err ? ERR : REQ) : IDLE;
      REQ: state_d = !psel ? IDLE : (reg_ack_i || tmo) ? RESP : REQ;
      ERR: state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    start = state_q == IDLE && setup && !dec_err;
    fin_ack = state_q == REQ && psel && reg_ack_i;
    done = state_d == RESP;
    req_d = state_d == REQ;
    we_d = start ? pwrite : we_q;
    idx_d = start ? idx : idx_q;
    strb_d = start ? (pwrite ? pstrb : '0) : strb_q;
    wdata_d = start ? pwdata : wdata_q;
    cnt_d = state_q == REQ ? cnt_q + 1'b1 : '0;
    tmo_d = state_q == REQ && psel && !reg_ack_i && tmo;
    pready_d = done;
    pslverr_d = done && (fin_ack ? reg_err_i : 1'b1);
    prdata_d = fin_ack && !we_q && !reg_err_i ? reg_rdata_i : '0;
  end
  assign pready = pready_q;
  assign pslverr = pslverr_q;
  assign prdata = prdata_q;
  assign timeout_o = tmo_q;
  assign reg_req_o = req_q;
  assign reg_we_o = we_q;
  assign reg_idx_o = idx_q;
  assign reg_strb_o = strb_q;
  assign reg_wdata_o = wdata_q;
endmodule

// File: tb/tb_apb_reg_bridge.sv
// tb_apb_reg_bridge: directed checks of apb_reg_bridge with default and a 64-bit/8-register configuration.
module tb_apb_reg_bridge;
  logic pclk = 0, preset = 0, psel = 0, penable = 0, pwrite = 0;
  logic [11:0] paddr = 0;
  logic [3:0] pstrb = 0;
  logic [31:0] pwdata = 0, prdata, reg_wdata_o, reg_rdata_i = 0;
  logic pready, pslverr, reg_req_o, reg_we_o, reg_ack_i = 0, reg_err_i = 0, timeout_o;
  logic [2:0] reg_idx_o;
  logic [3:0] reg_strb_o;
  logic psel2 = 0, penable2 = 0, pwrite2 = 0, ack2 = 0;
  logic [11:0] paddr2 = 0;
  logic [7:0] pstrb2 = 0, strb2;
  logic [63:0] pwdata2 = 0, prdata2, wdata2, rdata2 = 0;
  logic pready2, pslverr2, req2, we2, tmo2;
  logic [2:0] idx2;
  int checks = 0, failures = 0;
  int lat, nreq, ntmo;
  logic [31:0] prd, cap_wdata;
  logic err, cap_we;
  logic [2:0] cap_idx;
  logic [3:0] cap_strb;

  apb_reg_bridge dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pstrb(pstrb), .pwdata(pwdata), .pready(pready), .pslverr(pslverr),
    .prdata(prdata), .reg_req_o(reg_req_o), .reg_we_o(reg_we_o), .reg_idx_o(reg_idx_o),
    .reg_strb_o(reg_strb_o), .reg_wdata_o(reg_wdata_o), .reg_ack_i(reg_ack_i),
    .reg_err_i(reg_err_i), .reg_rdata_i(reg_rdata_i), .timeout_o(timeout_o));

  apb_reg_bridge #(.DATA_W(64), .NUM_REGS(8), .BASE_ADDR(12'h100), .REG_STRIDE(8),
    .RO_MASK(8'h00)) dut2 (
    .pclk(pclk), .preset(preset), .psel(psel2), .penable(penable2), .pwrite(pwrite2),
    .paddr(paddr2), .pstrb(pstrb2), .pwdata(pwdata2), .pready(pready2), .pslverr(pslverr2),
    .prdata(prdata2), .reg_req_o(req2), .reg_we_o(we2), .reg_idx_o(idx2),
    .reg_strb_o(strb2), .reg_wdata_o(wdata2), .reg_ack_i(ack2),
    .reg_err_i(1'b0), .reg_rdata_i(rdata2), .timeout_o(tmo2));

  always #5 pclk = ~pclk;

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // One APB transfer starting in the current cycle; ack_at = REQ cycle (0-based) carrying the ack, -1 = never.
  task automatic xfer(input logic w, input logic [11:0] a, input logic [31:0] wd, input logic [3:0] st,
                      input int ack_at, input logic [31:0] rd, input logic er);
    psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = wd; pstrb = st;
    lat = 0; nreq = 0; ntmo = 0;
    step();
    lat = 1; penable = 1;
    while (!pready && lat < 40) begin
      if (reg_req_o) begin
        nreq++;
        if (nreq == 1) begin
          cap_idx = reg_idx_o; cap_we = reg_we_o; cap_strb = reg_strb_o; cap_wdata = reg_wdata_o;
        end
      end
      reg_ack_i = reg_req_o && (nreq - 1 == ack_at);
      reg_err_i = er; reg_rdata_i = rd;
      step();
      lat++;
      if (timeout_o) ntmo++;
    end
    reg_ack_i = 0; reg_err_i = 0;
    prd = prdata; err = pslverr;
    psel = 0; penable = 0;
    step();
    chk("pready_drop", pready, 0);
    chk("prdata_drop", prdata, 0);
    chk("tmo_drop", timeout_o, 0);
  endtask

  initial begin
    preset = 1;
    step(); step();
    preset = 0;
    chk("rst_pready", pready, 0);
    chk("rst_pslverr", pslverr, 0);
    chk("rst_req", reg_req_o, 0);
    chk("rst_idx", reg_idx_o, 0);
    chk("rst_wdata", reg_wdata_o, 0);
    chk("rst_tmo", timeout_o, 0);

    xfer(1, 12'h008, 32'hA5A5_00FF, 4'b0011, 2, 0, 0);
    chk("w2_lat", lat, 4);
    chk("w2_idx", cap_idx, 2);
    chk("w2_we", cap_we, 1);
    chk("w2_strb", cap_strb, 4'b0011);
    chk("w2_wdata", cap_wdata, 32'hA5A5_00FF);
    chk("w2_nreq", nreq, 3);
    chk("w2_err", err, 0);

    xfer(0, 12'h010, 0, 4'hF, 0, 32'h0000_0013, 0);
    chk("r4_lat", lat, 2);
    chk("r4_prdata", prd, 32'h13);
    chk("r4_err", err, 0);
    chk("r4_strb", cap_strb, 0);
    chk("r4_idx", cap_idx, 4);

    xfer(1, 12'h010, 32'h1234, 4'hF, 0, 0, 0);
    chk("w4ro_nreq", nreq, 0);
    chk("w4ro_lat", lat, 2);
    chk("w4ro_err", err, 1);

    xfer(0, 12'h014, 0, 0, 0, 32'hDEAD, 0);
    chk("unmap_nreq", nreq, 0);
    chk("unmap_lat", lat, 2);
    chk("unmap_err", err, 1);
    chk("unmap_prdata", prd, 0);

    xfer(0, 12'h006, 0, 0, 0, 32'hDEAD, 0);
    chk("misal_nreq", nreq, 0);
    chk("misal_lat", lat, 2);
    chk("misal_err", err, 1);

    xfer(0, 12'h004, 0, 0, -1, 32'hDEAD, 0);
    chk("tmo_nreq", nreq, 16);
    chk("tmo_lat", lat, 17);
    chk("tmo_pulse", ntmo, 1);
    chk("tmo_err", err, 1);
    chk("tmo_prdata", prd, 0);

    xfer(0, 12'h004, 0, 0, 15, 32'h0000_BEEF, 0);
    chk("late_lat", lat, 17);
    chk("late_tmo", ntmo, 0);
    chk("late_err", err, 0);
    chk("late_prdata", prd, 32'hBEEF);

    xfer(0, 12'h00C, 0, 0, 1, 32'hFFFF_FFFF, 1);
    chk("rerr_lat", lat, 3);
    chk("rerr_err", err, 1);
    chk("rerr_prdata", prd, 0);

    xfer(1, 12'h000, 32'h55, 4'b0000, 0, 0, 0);
    chk("strb0_nreq", nreq, 1);
    chk("strb0_strb", cap_strb, 0);
    chk("strb0_err", err, 0);

    psel = 1; penable = 1; paddr = 12'h000; pwrite = 0;
    step();
    chk("viol_req", reg_req_o, 0);
    step();
    chk("viol_pready", pready, 0);
    psel = 1; penable = 0;
    step();
    chk("abort_req_on", reg_req_o, 1);
    psel = 0; penable = 0;
    step();
    chk("abort_req_off", reg_req_o, 0);
    step();
    chk("abort_pready", pready, 0);

    psel = 1; penable = 0; paddr = 12'h004; pwrite = 0;
    step();
    penable = 1;
    chk("rst_mid_req", reg_req_o, 1);
    preset = 1;
    step();
    preset = 0; psel = 0; penable = 0;
    chk("rst_mid_req_off", reg_req_o, 0);
    chk("rst_mid_pready", pready, 0);
    chk("rst_mid_idx", reg_idx_o, 0);
    xfer(0, 12'h000, 0, 0, 0, 32'h0000_0A0A, 0);
    chk("b2b0_lat", lat, 2);
    chk("b2b0_prdata", prd, 32'h0A0A);
    xfer(0, 12'h004, 0, 0, 0, 32'h0000_0B0B, 0);
    chk("b2b1_lat", lat, 2);
    chk("b2b1_idx", cap_idx, 1);
    chk("b2b1_prdata", prd, 32'h0B0B);

    psel2 = 1; penable2 = 0; paddr2 = 12'h138; pwrite2 = 0;
    step();
    penable2 = 1;
    chk("p_req", req2, 1);
    chk("p_idx7", idx2, 7);
    ack2 = 1; rdata2 = 64'h0123_4567_89AB_CDEF;
    step();
    ack2 = 0; psel2 = 0; penable2 = 0;
    chk("p_pready", pready2, 1);
    chk("p_prdata", prdata2, 64'h0123_4567_89AB_CDEF);
    chk("p_err", pslverr2, 0);
    step();
    psel2 = 1; penable2 = 0; paddr2 = 12'h140;
    step();
    penable2 = 1;
    chk("p_unmap_req", req2, 0);
    step();
    psel2 = 0; penable2 = 0;
    chk("p_unmap_pready", pready2, 1);
    chk("p_unmap_err", pslverr2, 1);
    step();
    psel2 = 1; penable2 = 0; paddr2 = 12'h0F8;
    step();
    penable2 = 1;
    chk("p_below_req", req2, 0);
    step();
    psel2 = 0; penable2 = 0;
    chk("p_below_err", pslverr2, 1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_reg_bridge.md
Name: apb_reg_bridge

Overview:
- Parametrised APB completer that bridges an APB bus to a simple indexed register-file handshake. It is the successor to the fixed-map UART APB slave.
- Generalised in data/address width, register count, base address, stride and per-register read-only mask.
- Adds a req/ack wait-state handshake, a timeout with error response, and registered pready/pslverr/prdata.
- Sits between the APB interconnect and any peripheral register block (UART first).

Parameters:
- ADDR_W, 12, APB address width.
- DATA_W, 32, APB data width; multiple of 8. STRB_W = DATA_W/8.
- NUM_REGS, 5, number of mapped registers (>=1).
- BASE_ADDR, 12'h000, byte address of register 0.
- REG_STRIDE, 4, byte spacing between registers; power of two, >= STRB_W.
- RO_MASK, 5'b10010, NUM_REGS bits; bit i=1 makes register i read-only.
- TIMEOUT, 16, max cycles reg_req_o is held without reg_ack_i (>=2).

Ports:
- pclk  in  1  clock, rising edge
- preset  in  1  synchronous reset, active-high
- psel  in  1  APB select
- penable  in  1  APB enable
- pwrite  in  1  APB write
- paddr  in  ADDR_W  APB address
- pstrb  in  STRB_W  APB write strobes
- pwdata  in  DATA_W  APB write data
- pready  out  1  APB ready (registered)
- pslverr  out  1  APB error (registered, valid only with pready)
- prdata  out  DATA_W  APB read data (registered)
- reg_req_o  out  1  register access request
- reg_we_o  out  1  1=write, 0=read
- reg_idx_o  out  IDX_W=max(1,$clog2(NUM_REGS))  register index
- reg_strb_o  out  STRB_W  write strobes (0 on reads)
- reg_wdata_o  out  DATA_W  write data
- reg_ack_i  in  1  register access done
- reg_err_i  in  1  register-side error, sampled with reg_ack_i
- reg_rdata_i  in  DATA_W  read data, sampled with reg_ack_i
- timeout_o  out  1  one-cycle pulse when an access times out

Behaviour:
- Reset (preset=1 at an edge): state=IDLE. pready, pslverr, prdata, reg_req_o, reg_we_o, reg_idx_o, reg_strb_o, reg_wdata_o, timeout_o and the timeout counter all =0.
- Reset mid-access drops reg_req_o at that edge; no response is produced.
- FSM states: IDLE, REQ, ERR, RESP.
- IDLE:
  - On psel=1 and penable=0, latch pwrite, pstrb and pwdata, and decode paddr.
  - Decode: off = paddr - BASE_ADDR. The address is mapped iff paddr >= BASE_ADDR, off < NUM_REGS*REG_STRIDE, and off mod REG_STRIDE == 0. idx = off/REG_STRIDE.
  - Decode error if: unmapped; misaligned; or pwrite=1 with RO_MASK[idx]=1.
  - Decode error -> ERR. Otherwise -> REQ with reg_req_o=1, reg_we_o=pwrite, reg_idx_o=idx, reg_strb_o=(pwrite ? pstrb : 0), reg_wdata_o=pwdata, counter=0.
  - psel=1 with penable=1 in IDLE is ignored (protocol violation).
- REQ:
  - reg_req_o and the request fields are held stable; the counter increments each cycle.
  - reg_ack_i=1 -> RESP with pslverr=reg_err_i and prdata=(read and no reg_err_i ? reg_rdata_i : 0). reg_req_o=0 on the same edge.
  - No ack and counter==TIMEOUT-1 -> RESP with pslverr=1, prdata=0, reg_req_o=0, timeout_o=1 for one cycle.
  - If ack and timeout coincide, ack wins (no timeout_o).
  - psel=0 in REQ (master abort) -> IDLE, reg_req_o=0, no pready.
- ERR: one cycle, no register request -> RESP with pslverr=1, prdata=0.
- RESP:
  - pready=1 for exactly one cycle.
  - Next state is IDLE; pready, pslverr and prdata return to 0 on the next edge.
- Latency (setup cycle = T0):
  - Ack in the first REQ cycle gives pready=1 in T2, i.e. one APB wait state minimum.
  - Decode errors also give pready in T2.
  - Timeout gives pready in T1+TIMEOUT.
- Back-to-back: a new setup phase is accepted in the IDLE cycle immediately following RESP.
- A write with pstrb=0 is legal; it is forwarded with reg_strb_o=0.
- reg_ack_i is ignored outside REQ.

Test Plan:
- Write idx2: paddr=0x008, pwdata=0xA5A5_00FF, pstrb=4'b0011, ack after 3 REQ cycles -> reg_idx_o=2, reg_we_o=1, reg_strb_o=0011; pready at T4; pslverr=0.
- Read idx4 (RO): ack in the first cycle with reg_rdata_i=0x0000_0013 -> pready at T2, prdata=0x13, pslverr=0. Then write idx4 -> no reg_req_o, pready at T2, pslverr=1.
- Unmapped paddr=0x014 and misaligned paddr=0x006 -> no reg_req_o, pready at T2, pslverr=1, prdata=0.
- No ack with TIMEOUT=16 -> reg_req_o high for 16 cycles, timeout_o pulse, pready at T17, pslverr=1. Repeat with ack on the last cycle -> pslverr=reg_err_i, no timeout_o.
- preset=1 while in REQ, then two back-to-back reads (idx0, idx1) -> reset clears all outputs in the next cycle; both reads complete with correct prdata and no lost transfer.
- Parametrisation: DATA_W=64, NUM_REGS=8, BASE_ADDR=0x100, REG_STRIDE=8 -> paddr=0x138 gives idx7; paddr=0x140 gives pslverr=1.
